// File: rtl/shared_cache_miss_controller.sv
// rtl/shared_cache_miss_controller.sv - shared data cache load-miss refill engine
// Optional build macro: MISS_CTRL_CRITICAL_WORD_FIRST_EN (start the refill at the missing word).
`timescale 1ns/1ps
module shared_cache_miss_controller #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss,
    input  logic              is_store,
    input  logic [ADDR_W-1:0] miss_address,
    output logic              stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_done
);
    localparam int OFS   = $clog2(LINE_WORDS * 8);
    localparam int IDX_W = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state;
    logic [ADDR_W-OFS-1:0] baseHi;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      beatCnt;
    logic [IDX_W-1:0]      startIdx;
    logic                  missLoad;
    logic                  beat;
    logic                  unusedAddrBits;

`ifdef MISS_CTRL_CRITICAL_WORD_FIRST_EN
    assign startIdx       = miss_address[OFS-1:3];
    assign unusedAddrBits = ^miss_address[2:0];
`else
    assign startIdx       = '0;
    assign unusedAddrBits = ^miss_address[OFS-1:0];
`endif

    // Store misses never allocate (write-through, no-write-allocate).
    assign missLoad = miss & ~is_store;
    assign stall    = (state == IDLE) ? missLoad : 1'b1;
    assign beat     = (state == REQ) && mem_ack;
    // Base has its offset bits cleared, so the beat address is a plain concatenation.
    assign mem_addr = {baseHi, idx, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baseHi    <= '0;
            idx       <= '0;
            beatCnt   <= '0;
            mem_req   <= 1'b0;
            fill_we   <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
            fill_done <= 1'b0;
        end else begin
            fill_we   <= beat;
            fill_done <= 1'b0;
            if (beat) begin
                fill_addr <= mem_addr;
                fill_data <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (missLoad) begin
                        baseHi  <= miss_address[ADDR_W-1:OFS];
                        idx     <= startIdx;
                        beatCnt <= '0;
                        mem_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        idx     <= idx + 1'b1;
                        beatCnt <= beatCnt + 1'b1;
                        if (beatCnt == IDX_W'(LINE_WORDS - 1)) begin
                            mem_req   <= 1'b0;
                            fill_done <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shared_cache_miss_controller.sv
// tb/tb_shared_cache_miss_controller.sv - randomized self-checking bench for the miss controller
`timescale 1ns/1ps
module tb_shared_cache_miss_controller;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        reset, miss, is_store, mem_ack;
    logic [63:0] miss_address, mem_rdata;
    logic        stall, mem_req, fill_we, fill_done;
    logic [63:0] mem_addr, fill_addr, fill_data;

    int vectors = 0;
    int miscompares = 0;

    shared_cache_miss_controller #(.LINE_WORDS(LW), .ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .reset(reset), .miss(miss), .is_store(is_store),
        .miss_address(miss_address), .stall(stall), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    // Reference: k-th beat address of the line holding byte address a.
    function automatic logic [63:0] beatAddr(input logic [63:0] a, input int k);
        logic [63:0] base;
        int start;
        base = a & ~64'(LW * 8 - 1);
`ifdef MISS_CTRL_CRITICAL_WORD_FIRST_EN
        start = int'((a >> 3) % LW);
`else
        start = 0;
`endif
        return base + 64'(((start + k) % LW) * 8);
    endfunction

    // Presents a load miss in the current IDLE cycle and serves the line with
    // minWait..maxWait wait cycles per beat; abortAfter >= 0 resets after that many beats.
    task automatic drive_refill(input logic [63:0] addr, input int minWait, input int maxWait,
                                input int abortAfter, output int stallCycles);
        logic [63:0] exp, prevA, prevD;
        logic prevBeat;
        int w, expStall;
        prevBeat = 1'b0; prevA = '0; prevD = '0;
        stallCycles = 0;
        expStall = LW + 2;
        @(negedge clk);
        miss = 1'b1; is_store = 1'b0; miss_address = addr; mem_ack = 1'b0;
        #1;
        vectors++;
        if ({stall, mem_req, fill_we, fill_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL miss_cycle addr=%h stall/req/we/done got %b want 1000", addr,
                     {stall, mem_req, fill_we, fill_done});
        end
        if (stall) stallCycles++;
        for (int k = 0; k < LW; k++) begin
            if (k == abortAfter) begin
                @(negedge clk);
                reset = 1'b1; miss = 1'b0; mem_ack = 1'(($urandom_range(1, 0)));
                #1;
                vectors++;
                if ({fill_we, fill_addr, fill_data} !== {1'b1, prevA, prevD}) begin
                    miscompares++;
                    $display("FAIL pre_abort_fill got we=%b a=%h d=%h want a=%h d=%h",
                             fill_we, fill_addr, fill_data, prevA, prevD);
                end
                @(negedge clk);
                reset = 1'b0; mem_ack = 1'b1;
                #1;
                vectors++;
                if ({stall, mem_req, mem_addr, fill_we, fill_done, fill_addr, fill_data} !== '0) begin
                    miscompares++;
                    $display("FAIL post_abort got stall=%b req=%b maddr=%h we=%b done=%b fa=%h fd=%h want all 0",
                             stall, mem_req, mem_addr, fill_we, fill_done, fill_addr, fill_data);
                end
                return;
            end
            w = int'($urandom_range(maxWait, minWait));
            expStall += w;
            exp = beatAddr(addr, k);
            for (int j = 0; j <= w; j++) begin
                @(negedge clk);
                miss = 1'($urandom_range(1, 0));
                is_store = 1'($urandom_range(1, 0));
                miss_address = {$urandom, $urandom};
                mem_ack = (j == w);
                mem_rdata = {$urandom, $urandom};
                #1;
                vectors++;
                if ({stall, mem_req, mem_addr} !== {1'b1, 1'b1, exp}) begin
                    miscompares++;
                    $display("FAIL beat%0d_req got stall=%b req=%b addr=%h want 1 1 %h",
                             k, stall, mem_req, mem_addr, exp);
                end
                vectors++;
                if (prevBeat) begin
                    if ({fill_we, fill_done, fill_addr, fill_data} !== {2'b10, prevA, prevD}) begin
                        miscompares++;
                        $display("FAIL fill_write got we=%b done=%b a=%h d=%h want 1 0 %h %h",
                                 fill_we, fill_done, fill_addr, fill_data, prevA, prevD);
                    end
                end else if ({fill_we, fill_done} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL fill_idle got we=%b done=%b want 0 0", fill_we, fill_done);
                end
                if (stall) stallCycles++;
                prevBeat = (j == w);
                prevA = exp;
                prevD = mem_rdata;
            end
        end
        @(negedge clk);
        miss = 1'($urandom_range(1, 0)); is_store = 1'b0;
        mem_ack = 1'($urandom_range(1, 0));
        #1;
        vectors++;
        if ({stall, mem_req, fill_we, fill_done, fill_addr, fill_data} !== {4'b1011, prevA, prevD}) begin
            miscompares++;
            $display("FAIL done_cycle got stall=%b req=%b we=%b done=%b a=%h d=%h want 1 0 1 1 %h %h",
                     stall, mem_req, fill_we, fill_done, fill_addr, fill_data, prevA, prevD);
        end
        if (stall) stallCycles++;
        vectors++;
        if (stallCycles !== expStall) begin
            miscompares++;
            $display("FAIL stall_length got %0d want %0d", stallCycles, expStall);
        end
    endtask

    task automatic idle_cycle(input logic strayAck);
        @(negedge clk);
        miss = 1'b0; is_store = 1'b0; mem_ack = strayAck;
        #1;
        vectors++;
        if ({stall, mem_req, fill_we, fill_done} !== 4'b0000) begin
            miscompares++;
            $display("FAIL idle got stall/req/we/done=%b want 0000", {stall, mem_req, fill_we, fill_done});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; miss = 1'b0; is_store = 1'b0; mem_ack = 1'b0;
        miss_address = '0; mem_rdata = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            vectors++;
            if ({stall, mem_req, fill_we, fill_done, mem_addr, fill_addr, fill_data} !== '0) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d got stall=%b req=%b we=%b done=%b maddr=%h fa=%h fd=%h want all 0",
                         i, stall, mem_req, fill_we, fill_done, mem_addr, fill_addr, fill_data);
            end
        end
    endtask

    task automatic test_load_miss();
        int sc;
        drive_refill(64'h528, 0, 0, -1, sc);
        vectors++;
        if (sc !== 6) begin
            miscompares++;
            $display("FAIL zero_wait_stall got %0d want 6", sc);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_store_miss();
        @(negedge clk);
        miss = 1'b1; is_store = 1'b1; miss_address = 64'h5A0; mem_ack = 1'b0;
        #1;
        vectors++;
        if ({stall, mem_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL store_miss got stall=%b req=%b want 0 0", stall, mem_req);
        end
        for (int i = 0; i < 3; i++) idle_cycle(1'b0);
    endtask

    task automatic test_wait_states();
        int sc;
        for (int i = 0; i < 3; i++) idle_cycle(1'b1);
        drive_refill(64'h540, 2, 2, -1, sc);
        vectors++;
        if (sc !== 14) begin
            miscompares++;
            $display("FAIL wait_state_stall got %0d want 14", sc);
        end
        idle_cycle(1'b0);
    endtask

    task automatic test_reset_mid_refill();
        int sc;
        drive_refill(64'h5C8, 0, 1, 2, sc);
        for (int i = 0; i < 3; i++) idle_cycle(1'($urandom_range(1, 0)));
        drive_refill(64'h500, 0, 0, -1, sc);
        idle_cycle(1'b0);
    endtask

    task automatic test_back_to_back();
        int sc;
        drive_refill(64'h1238, 0, 1, -1, sc);
        drive_refill(64'h7710, 1, 2, -1, sc);
        idle_cycle(1'b0);
    endtask

    task automatic test_random();
        int sc;
        for (int n = 0; n < 20; n++) begin
            drive_refill({$urandom, $urandom}, 0, 3, -1, sc);
            if ($urandom_range(1, 0) == 1) begin
                idle_cycle(1'($urandom_range(1, 0)));
                @(negedge clk);
                miss = 1'b1; is_store = 1'b1; miss_address = {$urandom, $urandom};
                #1;
                vectors++;
                if ({stall, mem_req} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL rand_store_miss got stall=%b req=%b want 0 0", stall, mem_req);
                end
            end
        end
        idle_cycle(1'b0);
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_miss();
        test_wait_states();
        test_reset_mid_refill();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
